phase_timer: RTL and testbench
==============================

PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 Parameter STATE_W, 4, width of the controller state code.
REQ-002 Parameter CNT_W, 6, width of the countdown counter.
REQ-003 Parameter RED_TIME, 1, duration in ticks for the all-red class.
REQ-004 Parameter PRIMARY_GREEN_TIME, 20, duration for the primary-green class.
REQ-005 Parameter EXTENDED_GREEN_TIME, 30, duration for the extended-green class.
REQ-006 Parameter YELLOW_TIME, 5, duration for the yellow class.
REQ-007 Parameter EXT_STEP, 10, ticks added per accepted extension request.
REQ-008 Parameter MAX_EXT, 2, maximum accepted extensions per phase.
REQ-009 clk  in  1  system clock; all state changes on the rising edge.
REQ-010 rst  in  1  reset, asynchronous, active-high.
REQ-011 state  in  STATE_W  current controller state code.
REQ-012 tick_en  in  1  count enable; one tick consumed per cycle it is high.
REQ-013 hold  in  1  freeze countdown (pedestrian/pre-emption pause).
REQ-014 ext_req  in  1  request to extend the current green phase.
REQ-015 expired  out  1  one-cycle pulse when the phase countdown reaches zero.
REQ-016 remaining  out  CNT_W  ticks left in the current phase.
REQ-017 busy  out  1  high while the FSM is in RUN.
REQ-018 ext_used  out  clog2(MAX_EXT+1)  extensions accepted in the current phase.

Function
REQ-019 The block SHALL decode state into classes: 0 -> RED; 1,4,7,10 -> PRIMARY_GREEN; 2,5,8,11 -> EXTENDED_GREEN; 3,6,9,12 -> YELLOW; all others -> RED.
REQ-020 Class duration SHALL be the matching parameter; a parameter of 0 SHALL be treated as 1.
REQ-021 The FSM SHALL have states IDLE, RUN, DONE.
REQ-022 IDLE -> RUN on the first clock after reset: load remaining with the duration of the current state, capture state into state_q.
REQ-023 In RUN or DONE, state != state_q SHALL reload remaining, clear ext_used, update state_q, enter RUN; reload has priority over tick and ext_req that cycle.
REQ-024 In RUN with tick_en=1 and hold=0: remaining>1 -> remaining-1; remaining==1 -> remaining<=0, expired<=1 on that same edge, FSM -> DONE.
REQ-025 hold=1 SHALL freeze remaining regardless of tick_en; hold has no effect on reload or ext_req.
REQ-026 expired SHALL be registered and high for exactly one cycle per phase; never asserted on a reload cycle.
REQ-027 In RUN, ext_req=1 with a green class and ext_used<MAX_EXT SHALL set remaining <= remaining+EXT_STEP (saturating at 2^CNT_W-1) and increment ext_used; the tick that cycle is not consumed.
REQ-028 ext_req SHALL be ignored in IDLE, DONE, non-green classes, or when ext_used==MAX_EXT.
REQ-029 ext_req coincident with a remaining==1 tick SHALL extend and suppress expiry.
REQ-030 DONE SHALL hold remaining=0, expired=0 until a state change.
REQ-031 busy SHALL equal (FSM==RUN).

Reset
REQ-032 rst=1 SHALL immediately force FSM=IDLE, remaining=0, expired=0, ext_used=0, state_q=0, busy=0, including mid-countdown.
REQ-033 After rst deasserts, behaviour SHALL follow REQ-022 on the next rising edge.

Structure
REQ-034 Phase-class typedef (RED, PRIMARY_GREEN, EXTENDED_GREEN, YELLOW), default durations and the state-to-class decode function SHALL live in shared package traffic_pkg.
REQ-035 Decode and duration lookup SHALL be one combinational sub-module phase_decode; phase_timer instantiates it once.
REQ-036 Elaboration SHALL fail if any duration or EXT_STEP exceeds 2^CNT_W-1.

Verification
REQ-037 Reset, state=1, tick_en=1 -> remaining=20 after load, expired pulses once 20 cycles later, remaining=0, busy=0.
REQ-038 state=1, hold=1 for 5 cycles at remaining=12 -> remaining stays 12, expiry delayed by exactly 5 cycles.
REQ-039 state=1, ext_req at remaining=3, 8, 4 -> remaining 13, then 18; third request ignored, ext_used=2.
REQ-040 state 1->3 at remaining=7 -> next cycle remaining=5, ext_used=0, no expired pulse.
REQ-041 ext_req with remaining==1 and tick -> remaining=11, expired stays 0; state=3 ext_req -> ignored.
REQ-042 rst pulsed at remaining=12 -> remaining=0, expired=0, busy=0 immediately; after release remaining reloads to 20.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types, default phase durations and the state-code to phase-class decode
// used by the traffic phase timer.
package traffic_pkg;

   typedef enum logic [1:0] {RED, PRIMARY_GREEN, EXTENDED_GREEN, YELLOW} phase_class_t;
   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_state_t;

   localparam int DEF_RED_TIME            = 1;
   localparam int DEF_PRIMARY_GREEN_TIME  = 20;
   localparam int DEF_EXTENDED_GREEN_TIME = 30;
   localparam int DEF_YELLOW_TIME         = 5;
   localparam int DEF_EXT_STEP            = 10;
   localparam int DEF_MAX_EXT             = 2;

   // Codes 1..12 cycle through green/extended-green/yellow; everything else is all-red.
   function automatic phase_class_t decode_class(input logic [31:0] code);
      phase_class_t cls;
      case (code)
         32'd1, 32'd4, 32'd7, 32'd10: cls = PRIMARY_GREEN;
         32'd2, 32'd5, 32'd8, 32'd11: cls = EXTENDED_GREEN;
         32'd3, 32'd6, 32'd9, 32'd12: cls = YELLOW;
         default:                     cls = RED;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/phase_decode.sv
// Combinational decode of a controller state code into its phase class and
// countdown duration; zero-valued durations are promoted to one tick.
module phase_decode
   import traffic_pkg::*;
#(
   parameter int STATE_W             = 4,
   parameter int CNT_W               = 6,
   parameter int RED_TIME            = DEF_RED_TIME,
   parameter int PRIMARY_GREEN_TIME  = DEF_PRIMARY_GREEN_TIME,
   parameter int EXTENDED_GREEN_TIME = DEF_EXTENDED_GREEN_TIME,
   parameter int YELLOW_TIME         = DEF_YELLOW_TIME
) (
   input  logic [STATE_W-1:0] state,
   output phase_class_t       cls,
   output logic [CNT_W-1:0]   duration
);

   localparam logic [CNT_W-1:0] RED_D = CNT_W'((RED_TIME == 0) ? 1 : RED_TIME);
   localparam logic [CNT_W-1:0] PG_D  = CNT_W'((PRIMARY_GREEN_TIME == 0) ? 1 : PRIMARY_GREEN_TIME);
   localparam logic [CNT_W-1:0] EG_D  = CNT_W'((EXTENDED_GREEN_TIME == 0) ? 1 : EXTENDED_GREEN_TIME);
   localparam logic [CNT_W-1:0] YEL_D = CNT_W'((YELLOW_TIME == 0) ? 1 : YELLOW_TIME);

   always_comb begin
      cls      = decode_class(32'(state));
      duration = RED_D;
      case (cls)
         PRIMARY_GREEN:  duration = PG_D;
         EXTENDED_GREEN: duration = EG_D;
         YELLOW:         duration = YEL_D;
         default:        duration = RED_D;
      endcase
   end

endmodule

// File: rtl/phase_timer.sv
// Phase countdown timer: loads the duration of the current controller state,
// counts enabled ticks down to a one-cycle expiry pulse, and accepts bounded green extensions.
module phase_timer
   import traffic_pkg::*;
#(
   parameter int STATE_W             = 4,
   parameter int CNT_W               = 6,
   parameter int RED_TIME            = DEF_RED_TIME,
   parameter int PRIMARY_GREEN_TIME  = DEF_PRIMARY_GREEN_TIME,
   parameter int EXTENDED_GREEN_TIME = DEF_EXTENDED_GREEN_TIME,
   parameter int YELLOW_TIME         = DEF_YELLOW_TIME,
   parameter int EXT_STEP            = DEF_EXT_STEP,
   parameter int MAX_EXT             = DEF_MAX_EXT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [STATE_W-1:0]           state,
   input  logic                         tick_en,
   input  logic                         hold,
   input  logic                         ext_req,
   output logic                         expired,
   output logic [CNT_W-1:0]             remaining,
   output logic                         busy,
   output logic [$clog2(MAX_EXT+1)-1:0] ext_used,
   output fsm_state_t                   dbg_fsm
);

   localparam int EXT_W   = $clog2(MAX_EXT + 1);
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam logic [EXT_W-1:0] MAX_EXT_V = EXT_W'(MAX_EXT);

   if (RED_TIME > CNT_MAX || PRIMARY_GREEN_TIME > CNT_MAX || EXTENDED_GREEN_TIME > CNT_MAX ||
       YELLOW_TIME > CNT_MAX || EXT_STEP > CNT_MAX) begin : g_bad_param
      $error("phase_timer: a duration or EXT_STEP does not fit in CNT_W bits");
   end

   phase_class_t       cls;
   logic [CNT_W-1:0]   duration;
   fsm_state_t         fsm_q, fsm_d;
   logic [STATE_W-1:0] state_q, state_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic               exp_q, exp_d;
   logic [EXT_W-1:0]   used_q, used_d;
   logic [CNT_W:0]     ext_sum;
   logic               ext_ok;

   phase_decode #(
      .STATE_W             (STATE_W),
      .CNT_W               (CNT_W),
      .RED_TIME            (RED_TIME),
      .PRIMARY_GREEN_TIME  (PRIMARY_GREEN_TIME),
      .EXTENDED_GREEN_TIME (EXTENDED_GREEN_TIME),
      .YELLOW_TIME         (YELLOW_TIME)
   ) u_decode (
      .state    (state),
      .cls      (cls),
      .duration (duration)
   );

   // Extra top bit catches overflow so the extension saturates instead of wrapping.
   assign ext_sum = {1'b0, rem_q} + (CNT_W + 1)'(EXT_STEP);
   assign ext_ok  = ext_req && (cls == PRIMARY_GREEN || cls == EXTENDED_GREEN) && (used_q < MAX_EXT_V);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         rem_q   <= '0;
         exp_q   <= 1'b0;
         used_q  <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         rem_q   <= rem_d;
         exp_q   <= exp_d;
         used_q  <= used_d;
      end
   end

   // A state change reloads ahead of any tick or extension in the same cycle.
   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      rem_d   = rem_q;
      exp_d   = 1'b0;
      used_d  = used_q;
      case (fsm_q)
         IDLE: begin
            fsm_d   = RUN;
            state_d = state;
            rem_d   = duration;
            used_d  = '0;
         end
         RUN, DONE: begin
            if (state != state_q) begin
               fsm_d   = RUN;
               state_d = state;
               rem_d   = duration;
               used_d  = '0;
            end else if (fsm_q == RUN) begin
               if (ext_ok) begin
                  rem_d  = ext_sum[CNT_W] ? {CNT_W{1'b1}} : ext_sum[CNT_W-1:0];
                  used_d = used_q + EXT_W'(1);
               end else if (tick_en && !hold) begin
                  if (rem_q > CNT_W'(1)) begin
                     rem_d = rem_q - CNT_W'(1);
                  end else begin
                     rem_d = '0;
                     exp_d = 1'b1;
                     fsm_d = DONE;
                  end
               end
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_comb begin
      busy      = (fsm_q == RUN);
      expired   = exp_q;
      remaining = rem_q;
      ext_used  = used_q;
      dbg_fsm   = fsm_q;
   end

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer: a vector table of single-cycle behaviours
// plus hand sequences for full countdowns, hold, extensions and reset.
module tb_phase_timer;
   import traffic_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] state;
   logic       tick_en, hold, ext_req;
   logic       expired, busy;
   logic [5:0] remaining;
   logic [1:0] ext_used;
   fsm_state_t dbg_fsm;

   int n_cmp  = 0;
   int n_fail = 0;
   int n;

   typedef struct {
      logic [3:0] st;
      logic       tk, hd, ex;
      logic [5:0] rem;
      logic       expd, bsy;
      logic [1:0] used;
   } vec_t;

   vec_t vecs[$];

   phase_timer dut (
      .clk       (clk),
      .rst       (rst),
      .state     (state),
      .tick_en   (tick_en),
      .hold      (hold),
      .ext_req   (ext_req),
      .expired   (expired),
      .remaining (remaining),
      .busy      (busy),
      .ext_used  (ext_used),
      .dbg_fsm   (dbg_fsm)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input int rem, input int expd, input int bsy, input int used);
      chk({name, ".remaining"}, 32'(remaining), 32'(rem));
      chk({name, ".expired"}, 32'(expired), 32'(expd));
      chk({name, ".busy"}, 32'(busy), 32'(bsy));
      chk({name, ".ext_used"}, 32'(ext_used), 32'(used));
   endtask

   // Steps until expired is seen, returning the number of edges taken (budget bounded).
   task automatic run_to_expiry(input string name, output int cycles);
      cycles = 0;
      do begin
         step();
         cycles++;
      end while (!expired && cycles < 80);
      if (!expired) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: no expiry within %0d cycles", name, cycles);
      end
   endtask

   function automatic vec_t mk(input int st, tk, hd, ex, rem, expd, bsy, used);
      vec_t v;
      v.st = 4'(st); v.tk = 1'(tk); v.hd = 1'(hd); v.ex = 1'(ex);
      v.rem = 6'(rem); v.expd = 1'(expd); v.bsy = 1'(bsy); v.used = 2'(used);
      return v;
   endfunction

   initial begin
      // st, tick, hold, ext -> remaining, expired, busy, ext_used
      vecs.push_back(mk(4, 1, 0, 1, 20, 0, 1, 0));
      vecs.push_back(mk(4, 0, 0, 0, 20, 0, 1, 0));
      vecs.push_back(mk(4, 1, 1, 0, 20, 0, 1, 0));
      vecs.push_back(mk(4, 1, 1, 1, 30, 0, 1, 1));
      vecs.push_back(mk(4, 1, 0, 0, 29, 0, 1, 1));
      vecs.push_back(mk(5, 1, 1, 0, 30, 0, 1, 0));
      vecs.push_back(mk(5, 1, 0, 1, 40, 0, 1, 1));
      vecs.push_back(mk(5, 1, 0, 1, 50, 0, 1, 2));
      vecs.push_back(mk(5, 1, 0, 1, 49, 0, 1, 2));
      vecs.push_back(mk(3, 1, 0, 1,  5, 0, 1, 0));
      vecs.push_back(mk(3, 1, 0, 1,  4, 0, 1, 0));
      vecs.push_back(mk(3, 1, 0, 0,  3, 0, 1, 0));
      vecs.push_back(mk(3, 1, 0, 0,  2, 0, 1, 0));
      vecs.push_back(mk(3, 1, 0, 0,  1, 0, 1, 0));
      vecs.push_back(mk(3, 1, 0, 0,  0, 1, 0, 0));
      vecs.push_back(mk(3, 1, 0, 0,  0, 0, 0, 0));
      vecs.push_back(mk(3, 1, 0, 1,  0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,  1, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 1,  0, 1, 0, 0));
      vecs.push_back(mk(13, 1, 0, 0, 1, 0, 1, 0));
      vecs.push_back(mk(13, 0, 0, 0, 1, 0, 1, 0));
      vecs.push_back(mk(15, 1, 0, 0, 1, 0, 1, 0));
      vecs.push_back(mk(15, 1, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(7, 1, 0, 0, 20, 0, 1, 0));
      vecs.push_back(mk(8, 1, 0, 0, 30, 0, 1, 0));
      vecs.push_back(mk(9, 1, 0, 0,  5, 0, 1, 0));
      vecs.push_back(mk(10, 1, 0, 0, 20, 0, 1, 0));
      vecs.push_back(mk(11, 1, 0, 0, 30, 0, 1, 0));
      vecs.push_back(mk(12, 1, 0, 0,  5, 0, 1, 0));
      vecs.push_back(mk(2, 1, 0, 0, 30, 0, 1, 0));
      vecs.push_back(mk(14, 1, 0, 0,  1, 0, 1, 0));

      // Reset state
      rst = 1'b1; state = 4'd0; tick_en = 1'b0; hold = 1'b0; ext_req = 1'b0;
      repeat (2) step();
      check_all("reset", 0, 0, 0, 0);
      chk("reset.fsm", 32'(dbg_fsm), 32'(IDLE));

      // Full primary-green countdown
      state = 4'd1; tick_en = 1'b1;
      rst = 1'b0;
      step();
      check_all("load", 20, 0, 1, 0);
      for (int i = 19; i >= 1; i--) begin
         step();
         check_all($sformatf("count%0d", i), i, 0, 1, 0);
      end
      step();
      check_all("expire", 0, 1, 0, 0);
      chk("expire.fsm", 32'(dbg_fsm), 32'(DONE));
      step();
      check_all("done", 0, 0, 0, 0);

      // Hold for 5 cycles at remaining=12 delays expiry by 5
      rst = 1'b1; #1; rst = 1'b0;
      step();
      check_all("hold.load", 20, 0, 1, 0);
      repeat (8) step();
      check_all("hold.at12", 12, 0, 1, 0);
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check_all($sformatf("hold.frozen%0d", i), 12, 0, 1, 0);
      end
      hold = 1'b0;
      run_to_expiry("hold.expiry", n);
      chk("hold.tail", 32'(n), 32'd12);
      chk("hold.total", 32'(8 + 5 + n), 32'd25);

      // Asynchronous reset in mid-countdown
      rst = 1'b1; #1; rst = 1'b0;
      step();
      repeat (8) step();
      check_all("rstmid.at12", 12, 0, 1, 0);
      rst = 1'b1;
      #1;
      check_all("rstmid.async", 0, 0, 0, 0);
      step();
      check_all("rstmid.held", 0, 0, 0, 0);
      rst = 1'b0;
      step();
      check_all("rstmid.reload", 20, 0, 1, 0);

      // Extensions at remaining 3, 8, 4
      repeat (17) step();
      check_all("ext.at3", 3, 0, 1, 0);
      ext_req = 1'b1; step(); ext_req = 1'b0;
      check_all("ext.first", 13, 0, 1, 1);
      repeat (5) step();
      check_all("ext.at8", 8, 0, 1, 1);
      ext_req = 1'b1; step(); ext_req = 1'b0;
      check_all("ext.second", 18, 0, 1, 2);
      repeat (14) step();
      check_all("ext.at4", 4, 0, 1, 2);
      ext_req = 1'b1; step(); ext_req = 1'b0;
      check_all("ext.third", 3, 0, 1, 2);

      // Vector table
      for (int i = 0; i < vecs.size(); i++) begin
         state = vecs[i].st; tick_en = vecs[i].tk; hold = vecs[i].hd; ext_req = vecs[i].ex;
         step();
         check_all($sformatf("vec%0d", i), int'(vecs[i].rem), int'(vecs[i].expd),
                   int'(vecs[i].bsy), int'(vecs[i].used));
      end
      ext_req = 1'b0; hold = 1'b0; tick_en = 1'b1;

      // Green to yellow change at remaining=7 clears extensions, no expiry
      state = 4'd1;
      step();
      check_all("chg.load", 20, 0, 1, 0);
      ext_req = 1'b1; step(); ext_req = 1'b0;
      check_all("chg.ext", 30, 0, 1, 1);
      repeat (23) step();
      check_all("chg.at7", 7, 0, 1, 1);
      state = 4'd3;
      step();
      check_all("chg.yellow", 5, 0, 1, 0);
      step();
      check_all("chg.next", 4, 0, 1, 0);

      // Extension coincident with the final tick suppresses expiry
      state = 4'd1;
      step();
      check_all("last.load", 20, 0, 1, 0);
      repeat (19) step();
      check_all("last.at1", 1, 0, 1, 0);
      ext_req = 1'b1; step(); ext_req = 1'b0;
      check_all("last.ext", 11, 0, 1, 1);
      run_to_expiry("last.expiry", n);
      chk("last.tail", 32'(n), 32'd11);
      check_all("last.expired", 0, 1, 0, 1);
      step();
      check_all("last.done", 0, 0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
